spi_xfer_ctrl: RTL

Sequences one console-initiated SPI transfer of 1..512 bytes on the shared SPI/TF serial pins. It fetches TX bytes from the TX buffer, shifts them out in SPI mode 0 (MSB first) and writes received bytes into the RX buffer. It runs in the FastClk domain, below the SPI_CNT register logic. Start, length, mode, device and divider arrive already synchronized to FastClk.

---
 rtl/spi_xfer_pkg.sv | 33 +++
 rtl/spi_halfperiod_tick.sv | 33 +++
 rtl/spi_xfer_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/spi_xfer_pkg.sv
// Shared types and constants for the SPI transfer sequencer.
package spi_xfer_pkg;

  typedef enum logic [1:0] {
    XFER_WRITE = 2'd0,
    XFER_READ  = 2'd1,
    XFER_EXCH  = 2'd2,
    XFER_RSVD  = 2'd3
  } xfer_mode_e;

  typedef enum logic [1:0] {
    DEV_NONE  = 2'd0,
    DEV_TF    = 2'd1,
    DEV_FLASH = 2'd2,
    DEV_MCU   = 2'd3
  } dev_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_SHIFT,
    ST_STORE
  } xfer_state_e;

  localparam logic [7:0] READ_FILL = 8'hFF;

  // Write and exchange shift real buffer data; read (and reserved) send fill bytes.
  function automatic logic uses_tx_data(input xfer_mode_e mode);
    return (mode == XFER_WRITE) || (mode == XFER_EXCH);
  endfunction

endpackage

// File: rtl/spi_halfperiod_tick.sv
// Free-running divider: one-cycle tick every 2^div clocks, restartable so the
// first period after restart is always full length.
module spi_halfperiod_tick #(
  parameter int DIV_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  localparam int CNT_W = (1 << DIV_W) - 1;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limit;

  assign limit = CNT_W'((32'd1 << div) - 32'd1);
  assign tick  = !restart && (count == limit);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Sequences one SPI mode-0 transfer of Length+1 bytes between the TX/RX
// buffers and the serial pins; chip selects simply follow DevSel.
module spi_xfer_ctrl
  import spi_xfer_pkg::*;
#(
  parameter int LEN_W = 9,
  parameter int DIV_W = 3
) (
  input  logic             FastClk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Abort,
  input  logic [LEN_W-1:0] Length,
  input  logic [1:0]       Mode,
  input  logic [1:0]       DevSel,
  input  logic [DIV_W-1:0] ClkDiv,
  output logic [LEN_W-1:0] TxAddr,
  input  logic [7:0]       TxData,
  output logic [LEN_W-1:0] RxAddr,
  output logic [7:0]       RxData,
  output logic             RxWe,
  output logic             SPIClk,
  output logic             SPIDo,
  input  logic             SPIDi,
  output logic             nTFSel,
  output logic             nFlashSel,
  output logic             nMCUSel,
  output logic             Busy,
  output logic             Done
);

  xfer_state_e      state_q, state_d;
  xfer_mode_e       mode_q;
  logic [LEN_W-1:0] len_q;
  logic [DIV_W-1:0] div_q;
  logic [LEN_W-1:0] index_q;
  logic [6:0]       tx_sreg;
  logic [7:0]       rx_sreg;
  logic [2:0]       bit_cnt;
  logic             done_q;
  logic             hp_tick;
  logic             last_byte;
  logic [7:0]       tx_byte;

  assign last_byte = (index_q == len_q);
  assign tx_byte   = uses_tx_data(mode_q) ? TxData : READ_FILL;

  spi_halfperiod_tick #(.DIV_W(DIV_W)) u_tick (
    .clk     (FastClk),
    .rst     (Reset),
    .restart (state_q != ST_SHIFT),
    .div     (div_q),
    .tick    (hp_tick)
  );

  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: next state gets its default first, so no path through the block
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (Start) state_d = ST_LOAD_A;
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: state_d = ST_SHIFT;
      ST_SHIFT:  if (hp_tick && SPIClk && bit_cnt == 3'd7) state_d = ST_STORE;
      ST_STORE:  state_d = last_byte ? ST_IDLE : ST_LOAD_A;
      default:   state_d = ST_IDLE;
    endcase
    if (Abort) state_d = ST_IDLE;
  end

  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      mode_q    <= XFER_WRITE;
      len_q     <= '0;
      div_q     <= '0;
      index_q   <= '0;
      tx_sreg   <= '0;
      rx_sreg   <= '0;
      bit_cnt   <= '0;
      SPIClk    <= 1'b0;
      SPIDo     <= 1'b1;
      done_q    <= 1'b0;
      nTFSel    <= 1'b1;
      nFlashSel <= 1'b1;
      nMCUSel   <= 1'b1;
    end else begin
      nTFSel    <= (DevSel != DEV_TF);
      nFlashSel <= (DevSel != DEV_FLASH);
      nMCUSel   <= (DevSel != DEV_MCU);
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start && !Abort) begin
            mode_q  <= xfer_mode_e'(Mode);
            len_q   <= Length;
            div_q   <= ClkDiv;
            index_q <= '0;
          end
        end
        ST_LOAD_B: begin
          tx_sreg <= tx_byte[6:0];
          SPIDo   <= tx_byte[7];
          bit_cnt <= '0;
        end
        ST_SHIFT: begin
          if (hp_tick) begin
            if (!SPIClk) begin
              SPIClk  <= 1'b1;
              rx_sreg <= {rx_sreg[6:0], SPIDi};
            end else begin
              // Shifting in ones leaves SPIDo high after the last bit.
              SPIClk  <= 1'b0;
              SPIDo   <= tx_sreg[6];
              tx_sreg <= {tx_sreg[5:0], 1'b1};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        ST_STORE: begin
          if (last_byte) done_q  <= 1'b1;
          else           index_q <= index_q + LEN_W'(1);
        end
        default: ;
      endcase
      if (Abort && state_q != ST_IDLE) begin
        SPIClk <= 1'b0;
        SPIDo  <= 1'b1;
        done_q <= 1'b0;
      end
    end
  end

  assign TxAddr = index_q;
  assign RxAddr = index_q;
  assign RxData = rx_sreg;
  assign RxWe   = (state_q == ST_STORE) && (mode_q != XFER_WRITE);
  assign Busy   = (state_q != ST_IDLE);
  assign Done   = done_q;

endmodule
